// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin front end for a single-port synchronous RAM.
// Every grant runs the fixed sequence IDLE -> ACCESS -> WAIT -> DONE, so a
// request sampled in IDLE completes with a done pulse three cycles later and
// the next grant can be taken one cycle after that.

// Per-port read-data holder: keeps the last word this port read.
module ram_arbiter_port #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] rdata
);

  // Load the RAM word when this port's read completes; hold it otherwise.
  always_ff @(posedge clock) begin
    if (reset)        rdata <= '0;
    else if (capture) rdata <= mem_dout;
  end

endmodule

module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t                           state, state_nxt;
  logic   [NUM_PORTS-1:0]           req_vld;
  req_t   [NUM_PORTS-1:0]           req_in;
  logic                             grant;      // some port is requesting
  logic                             win;        // port that would be granted now
  logic                             gnt;        // port owning the in-flight access
  logic                             last;       // last-served port
  logic                             write_flag; // in-flight access is a write
  logic   [NUM_PORTS-1:0]           done_v;
  logic   [NUM_PORTS-1:0]           capture;
  logic   [NUM_PORTS-1:0][DATA_W-1:0] rdata_v;

  assign req_vld   = {req1, req0};
  assign req_in[0] = {we0, adr0, wdata0};
  assign req_in[1] = {we1, adr1, wdata1};

  // Round-robin pick: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    grant = |req_vld;
    win   = 1'b0;
    if (&req_vld) win = ~last;
    else          win = req_vld[1];
  end

  // Sequencer next state and the state-decoded strobes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    mem_wr    = 1'b0;
    done_v    = '0;
    capture   = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant) state_nxt = ACCESS;
      end
      ACCESS: begin
        // The RAM takes the write on the edge leaving ACCESS, so one pulse per write.
        mem_wr    = write_flag;
        state_nxt = WAIT;
      end
      WAIT: begin
        // mem_dout now reflects the address presented in ACCESS.
        capture[gnt] = ~write_flag;
        state_nxt    = DONE;
      end
      DONE: begin
        done_v[gnt] = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Latch the winner's request on a grant so requesters are free to move on.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_adr    <= '0;
      mem_din    <= '0;
      write_flag <= 1'b0;
      gnt        <= 1'b0;
      last       <= 1'b1;
    end else if (state == IDLE && grant) begin
      mem_adr    <= req_in[win].adr;
      mem_din    <= req_in[win].wdata;
      write_flag <= req_in[win].we;
      gnt        <= win;
      last       <= win;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    ram_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .clock    (clock),
      .reset    (reset),
      .capture  (capture[i]),
      .mem_dout (mem_dout),
      .rdata    (rdata_v[i])
    );
  end

  assign done0  = done_v[0];
  assign done1  = done_v[1];
  assign rdata0 = rdata_v[0];
  assign rdata1 = rdata_v[1];

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width; it SHALL match the 256-word RAM.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 The clock port SHALL be `clock`, an input of width 1; it is the single clock and all state updates on its rising edge.
REQ-004 The reset port SHALL be `reset`, an input of width 1; it is synchronous and active-high.
REQ-005 Requester ports: `req0`, `req1`, inputs, width 1; access request from port 0 and from port 1.
REQ-006 Write-enable ports: `we0`, `we1`, inputs, width 1; 1 = write, 0 = read.
REQ-007 Address ports: `adr0`, `adr1`, inputs, width ADDR_W; word address.
REQ-008 Write-data ports: `wdata0`, `wdata1`, inputs, width DATA_W; write data.
REQ-009 Done ports: `done0`, `done1`, outputs, width 1; one-cycle completion pulse.
REQ-010 Read-data ports: `rdata0`, `rdata1`, outputs, width DATA_W; read data, valid while the matching done is high.
REQ-011 RAM address port: `mem_adr`, output, width ADDR_W; address to the RAM.
REQ-012 RAM write-data port: `mem_din`, output, width DATA_W; write data to the RAM.
REQ-013 RAM write strobe: `mem_wr`, output, width 1.
REQ-014 RAM read data: `mem_dout`, input, width DATA_W; the RAM drives it one clock after the address is presented.
REQ-015 `busy`, output, width 1; high in every state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, ACCESS, WAIT and DONE, with transitions IDLE->ACCESS, ACCESS->WAIT, WAIT->DONE and DONE->IDLE.
REQ-017 The block SHALL sample requests only in IDLE; with no request pending it SHALL stay in IDLE.
REQ-018 On a grant in IDLE, the block SHALL register the winner's adr, wdata and we into mem_adr, mem_din and a write flag, record the granted port, and enter ACCESS.
REQ-019 mem_wr SHALL be high only during ACCESS, and only when the write flag is 1; it is exactly one cycle per write.
REQ-020 mem_adr and mem_din SHALL hold their registered values from ACCESS through DONE.
REQ-021 At the WAIT->DONE edge, a read access SHALL capture mem_dout into the granted port's rdata register.
REQ-022 For a write access, rdata of the granted port SHALL hold its previous value.
REQ-023 In DONE, the done output of the granted port SHALL be high for exactly one cycle, and the other done output SHALL be 0.
REQ-024 Latency SHALL be fixed: a request sampled in IDLE at cycle t gives done at cycle t+3, and the next grant is possible at cycle t+4.
REQ-025 If only one of req0/req1 is high, that port SHALL be granted.
REQ-026 If both are high, the port not served last SHALL win (round-robin); the last-served pointer SHALL update on every grant.
REQ-027 rdata0 and rdata1 SHALL persist after done until that port's next read completes.
REQ-028 Requesters SHALL hold adr, we and wdata stable only for the IDLE sample cycle; later changes SHALL NOT affect the in-flight access.
REQ-029 A request that stays high through DONE SHALL be treated as a new request in the following IDLE cycle.
REQ-030 A request that drops before being sampled SHALL be ignored and produce no done.

Reset
REQ-031 When reset is high at a clock edge, the block SHALL enter IDLE, overriding any in-flight state.
REQ-032 The same reset edge SHALL clear to 0: mem_wr, done0, done1, busy, mem_adr, mem_din, rdata0, rdata1 and the write flag.
REQ-033 The same reset edge SHALL set last-served = 1, so port 0 wins the first simultaneous request.
REQ-034 A reset asserted in ACCESS, WAIT or DONE SHALL abort the access with no done pulse; mem_wr SHALL be 0 from the cycle after the reset edge.

Verification
REQ-035 Single write then read, port 0: write adr 0x05 with 0xDEADBEEF; mem_wr is high one cycle with mem_adr=0x05 and mem_din=0xDEADBEEF; done0 rises 3 cycles after the sample. Then read 0x05 -> rdata0=0xDEADBEEF when done0 pulses.
REQ-036 Simultaneous requests after reset: req0 and req1 both held, port 0 reading 0x10 and port 1 reading 0xC0 -> grants go port0, port1, port0, port1, with done pulses 4 cycles apart and each rdata matching its own address.
REQ-037 Bank boundaries: write and read addresses 0x3F, 0x40, 0x7F, 0x80, 0xBF, 0xC0 and 0xFF with distinct patterns -> every readback matches with no aliasing.
REQ-038 Input change mid-access: change adr0 and wdata0 during ACCESS -> the access completes with the values sampled in IDLE.
REQ-039 Reset during WAIT of a port-1 read -> no done1, busy=0 and state IDLE next cycle, rdata1=0; a following request completes normally.
REQ-040 Write-data isolation: port-1 write of 0x12345678 to 0x80 after a port-1 read of 0xA5A5A5A5 -> rdata1 stays 0xA5A5A5A5 through the write's done1.
